level_sequencer: RTL and testbench
==================================

// Module: level_sequencer
// PURPOSE
//   Sequences bomb-defusal rounds for game_controller: holds per-level config (initial_time, button_count),
//   issues round start, watches game_state for SUCCESS/FAILURE entry, advances difficulty or costs a life.
//   Replaces ad-hoc level logic in the top level; runs on game_clk (100 Hz) beside game_controller.
// PARAMETERS
//   BASE_TIME     1500  initial_time at level 0 (centiseconds)
//   TIME_STEP     100   initial_time decrement per level cleared
//   MIN_TIME      300   floor for initial_time
//   BASE_BUTTONS  6     button_count at level 0
//   MAX_BUTTONS   15    ceiling for button_count
//   MAX_LEVEL     15    level_num saturates here
//   LIVES         3     lives per game (1..3)
// PORTS
//   clk           in   1   game clock; all state updates on posedge
//   rst           in   1   synchronous, active-high reset
//   start_req     in   1   player start request (1-cycle pulse, active high)
//   game_state    in   2   from game_controller: 0 WAITING, 1 COUNTDOWN, 2 SUCCESS, 3 FAILURE
//   round_start   out  1   1-cycle start pulse to game_controller
//   initial_time  out  11  round time for game_controller
//   button_count  out  6   sequence length for game_controller
//   level_num     out  4   current level, 0-based
//   lives_left    out  2   remaining lives
//   level_up      out  1   1-cycle pulse when a level is cleared
//   game_over     out  1   high while in GAME_OVER
// BEHAVIOUR
//   Reset: state=IDLE, initial_time=BASE_TIME, button_count=BASE_BUTTONS, level_num=0, lives_left=LIVES,
//     round_start=0, level_up=0, game_over=0, gs_q=gs_qq=WAITING. All outputs registered.
//   game_state registered twice (gs_q, gs_qq). succ_edge = gs_q==2 && gs_qq!=2; fail_edge = gs_q==3 && gs_qq!=3.
//   FSM:
//     IDLE:      start_req -> round_start=1 next cycle, go WAIT_RUN.
//     WAIT_RUN:  gs_q==COUNTDOWN -> RUN. Edges ignored here; start_req ignored.
//     RUN:       succ_edge -> level_num=min(level_num+1,MAX_LEVEL);
//                  initial_time=max(initial_time-TIME_STEP, MIN_TIME) (12-bit compare, no wrap);
//                  button_count=min(BASE_BUTTONS+new level_num, MAX_BUTTONS); level_up=1; go IDLE.
//                fail_edge -> lives_left-1; if lives_left was 1: lives_left=0, go GAME_OVER;
//                  else keep level config, go IDLE (retry same level). start_req ignored.
//     GAME_OVER: game_over=1. start_req -> restore reset config, lives_left=LIVES, round_start=1, go WAIT_RUN.
//   Latency: game_state change sampled at edge k; gs_q/gs_qq edge visible after k; config/pulse outputs
//     update at edge k+1 (visible after k+1).
//   Pulses (round_start, level_up) are exactly one cycle; never both in the same cycle.
//   succ_edge and fail_edge are mutually exclusive by encoding; if game_state jumps 2->3, fail_edge applies
//     only if FSM is still in RUN (it is not: already IDLE).
//   Saturation: at MAX_LEVEL further clears keep level_num, still pulse level_up; time holds at MIN_TIME.
//   rst mid-round wins over all events in the same cycle; returns to reset values next edge.
// TESTING
//   rst 3 cycles -> initial_time=1500, button_count=6, level_num=0, lives_left=3, all pulses 0.
//   start_req; game_state 0->1->2 -> round_start 1 cycle; level_up 1 cycle; level=1, time=1400, buttons=7.
//   14 cleared rounds -> time clamps 300, buttons clamp 15; 16th clear keeps level_num=15.
//   3 rounds ending game_state=3 -> lives 2,1,0; game_over=1 after third; level config unchanged.
//   In GAME_OVER, start_req -> reset config, lives=3, round_start pulse, game_over drops.
//   rst asserted in RUN coincident with succ_edge -> no level_up; reset values next cycle.

Source files
------------

// File: rtl/level_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// level_sequencer: per-level round configuration, lives and round sequencing
// beside game_controller. Revision 1.0
// ----------------------------------------------------------------------------
module level_sequencer #(
  parameter int BASE_TIME    = 1500,
  parameter int TIME_STEP    = 100,
  parameter int MIN_TIME     = 300,
  parameter int BASE_BUTTONS = 6,
  parameter int MAX_BUTTONS  = 15,
  parameter int MAX_LEVEL    = 15,
  parameter int LIVES        = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_req,
  input  logic [1:0]  game_state,
  output logic        round_start,
  output logic [10:0] initial_time,
  output logic [5:0]  button_count,
  output logic [3:0]  level_num,
  output logic [1:0]  lives_left,
  output logic        level_up,
  output logic        game_over
);

  localparam logic [1:0] GS_WAITING   = 2'd0;
  localparam logic [1:0] GS_COUNTDOWN = 2'd1;
  localparam logic [1:0] GS_SUCCESS   = 2'd2;
  localparam logic [1:0] GS_FAILURE   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_RUN  = 2'd1,
    S_RUN       = 2'd2,
    S_GAME_OVER = 2'd3
  } state_t;

  state_t      state, state_n;
  logic [1:0]  gs_q, gs_qq;
  logic        succ_edge, fail_edge;
  logic [10:0] time_n;
  logic [5:0]  btn_n;
  logic [3:0]  level_n;
  logic [1:0]  lives_n;
  logic        round_start_n, level_up_n, game_over_n;

  logic [3:0]  level_inc;
  logic [11:0] time_ext;
  logic [10:0] time_dec;
  logic [6:0]  btn_sum;
  logic [5:0]  btn_next;

  assign succ_edge = (gs_q == GS_SUCCESS) && (gs_qq != GS_SUCCESS);
  assign fail_edge = (gs_q == GS_FAILURE) && (gs_qq != GS_FAILURE);

  // Difficulty step on a clear; the time subtraction is widened so it can never wrap.
  assign level_inc = (level_num == 4'(MAX_LEVEL)) ? level_num : level_num + 4'd1;
  assign time_ext  = {1'b0, initial_time};
  assign time_dec  = (time_ext >= 12'(TIME_STEP + MIN_TIME)) ?
                     11'(time_ext - 12'(TIME_STEP)) : 11'(MIN_TIME);
  assign btn_sum   = 7'(BASE_BUTTONS) + {3'b000, level_inc};
  assign btn_next  = (btn_sum > 7'(MAX_BUTTONS)) ? 6'(MAX_BUTTONS) : btn_sum[5:0];

  always_comb begin
    state_n       = state;
    time_n        = initial_time;
    btn_n         = button_count;
    level_n       = level_num;
    lives_n       = lives_left;
    round_start_n = 1'b0;
    level_up_n    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_req) begin
          round_start_n = 1'b1;
          state_n       = S_WAIT_RUN;
        end
      end
      S_WAIT_RUN: begin
        if (gs_q == GS_COUNTDOWN) state_n = S_RUN;
      end
      S_RUN: begin
        if (succ_edge) begin
          level_n    = level_inc;
          time_n     = time_dec;
          btn_n      = btn_next;
          level_up_n = 1'b1;
          state_n    = S_IDLE;
        end else if (fail_edge) begin
          if (lives_left <= 2'd1) begin
            lives_n = 2'd0;
            state_n = S_GAME_OVER;
          end else begin
            lives_n = lives_left - 2'd1;
            state_n = S_IDLE;
          end
        end
      end
      S_GAME_OVER: begin
        if (start_req) begin
          time_n        = 11'(BASE_TIME);
          btn_n         = 6'(BASE_BUTTONS);
          level_n       = 4'd0;
          lives_n       = 2'(LIVES);
          round_start_n = 1'b1;
          state_n       = S_WAIT_RUN;
        end
      end
      default: state_n = S_IDLE;
    endcase
    game_over_n = (state_n == S_GAME_OVER);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      gs_q         <= GS_WAITING;
      gs_qq        <= GS_WAITING;
      initial_time <= 11'(BASE_TIME);
      button_count <= 6'(BASE_BUTTONS);
      level_num    <= 4'd0;
      lives_left   <= 2'(LIVES);
      round_start  <= 1'b0;
      level_up     <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      state        <= state_n;
      gs_q         <= game_state;
      gs_qq        <= gs_q;
      initial_time <= time_n;
      button_count <= btn_n;
      level_num    <= level_n;
      lives_left   <= lives_n;
      round_start  <= round_start_n;
      level_up     <= level_up_n;
      game_over    <= game_over_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_level_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_level_sequencer: directed rounds with a scoreboard of expected output events.
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_level_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_req;
  logic [1:0]  game_state;
  logic        round_start;
  logic [10:0] initial_time;
  logic [5:0]  button_count;
  logic [3:0]  level_num;
  logic [1:0]  lives_left;
  logic        level_up;
  logic        game_over;

  level_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .start_req    (start_req),
    .game_state   (game_state),
    .round_start  (round_start),
    .initial_time (initial_time),
    .button_count (button_count),
    .level_num    (level_num),
    .lives_left   (lives_left),
    .level_up     (level_up),
    .game_over    (game_over)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rs;
    logic        lu;
    logic [3:0]  lvl;
    logic [10:0] tm;
    logic [5:0]  btn;
    logic [1:0]  lives;
    logic        go;
  } ev_t;

  ev_t q[$];
  int  checks = 0;
  int  errors = 0;
  bit  mon_en = 1'b0;

  // Expected config after the k-th consecutive clear from level 0.
  int exp_lvl[16]  = '{1,2,3,4,5,6,7,8,9,10,11,12,13,14,15,15};
  int exp_time[16] = '{1400,1300,1200,1100,1000,900,800,700,600,500,400,300,300,300,300,300};
  int exp_btn[16]  = '{7,8,9,10,11,12,13,14,15,15,15,15,15,15,15,15};

  int cur_lvl, cur_time, cur_btn, cur_lives;
  bit cur_go;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input bit rs, input bit lu);
    ev_t e;
    e.rs = rs; e.lu = lu;
    e.lvl = 4'(cur_lvl); e.tm = 11'(cur_time); e.btn = 6'(cur_btn);
    e.lives = 2'(cur_lives); e.go = cur_go;
    q.push_back(e);
  endtask

  task automatic set_reset_cfg();
    cur_lvl = 0; cur_time = 1500; cur_btn = 6; cur_lives = 3; cur_go = 0;
  endtask

  // success: nl/nt/nb are the hand-computed config after the clear
  task automatic run_round(input logic [1:0] res, input int nl, input int nt, input int nb);
    if (cur_go) set_reset_cfg();
    push(1'b1, 1'b0);
    @(posedge clk); #1 start_req = 1'b1;
    @(posedge clk); #1 start_req = 1'b0;
    game_state = 2'd1;
    repeat (3) @(posedge clk);
    #1 game_state = res;
    if (res == 2'd2) begin
      cur_lvl = nl; cur_time = nt; cur_btn = nb;
      push(1'b0, 1'b1);
    end else begin
      cur_lives = cur_lives - 1;
      cur_go = (cur_lives == 0);
      push(1'b0, 1'b0);
    end
    repeat (3) @(posedge clk);
    #1 game_state = 2'd0;
    repeat (2) @(posedge clk);
  endtask

  // Monitor: any pulse or a change of lives/game_over is an output event.
  logic [1:0] prev_lives;
  logic       prev_go;
  always @(negedge clk) begin
    if (mon_en) begin
      if (round_start && level_up) begin
        checks++; errors++;
        $display("FAIL pulse_overlap: round_start and level_up both high");
      end
      if (round_start || level_up || lives_left != prev_lives || game_over != prev_go) begin
        ev_t a, e;
        a = '{round_start, level_up, level_num, initial_time, button_count, lives_left, game_over};
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: got %h with nothing expected", a);
        end else begin
          e = q.pop_front();
          if (a != e) begin
            errors++;
            $display("FAIL event: got rs=%0d lu=%0d lvl=%0d t=%0d b=%0d lives=%0d go=%0d expected rs=%0d lu=%0d lvl=%0d t=%0d b=%0d lives=%0d go=%0d",
                     a.rs, a.lu, a.lvl, a.tm, a.btn, a.lives, a.go,
                     e.rs, e.lu, e.lvl, e.tm, e.btn, e.lives, e.go);
          end
        end
      end
    end
    prev_lives = lives_left;
    prev_go    = game_over;
  end

  initial begin
    rst = 1'b1; start_req = 1'b0; game_state = 2'd0;
    set_reset_cfg();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_time", int'(initial_time), 1500);
    chk("rst_buttons", int'(button_count), 6);
    chk("rst_level", int'(level_num), 0);
    chk("rst_lives", int'(lives_left), 3);
    chk("rst_pulses", int'({round_start, level_up, game_over}), 0);
    @(negedge clk); mon_en = 1'b1;

    for (int k = 0; k < 16; k++)
      run_round(2'd2, exp_lvl[k], exp_time[k], exp_btn[k]);
    chk("sat_level", int'(level_num), 15);
    chk("sat_time", int'(initial_time), 300);
    chk("sat_buttons", int'(button_count), 15);

    for (int k = 0; k < 3; k++) begin
      run_round(2'd3, 0, 0, 0);
      chk("fail_lives", int'(lives_left), 2 - k);
    end
    chk("game_over", int'(game_over), 1);
    chk("go_level_kept", int'(level_num), 15);
    chk("go_time_kept", int'(initial_time), 300);

    // Restart from GAME_OVER, then clear one level.
    run_round(2'd2, 1, 1400, 7);
    chk("restart_go_low", int'(game_over), 0);
    chk("restart_lives", int'(lives_left), 3);

    // Reset lands on the very edge that would act on the success edge.
    push(1'b1, 1'b0);
    @(posedge clk); #1 start_req = 1'b1;
    @(posedge clk); #1 start_req = 1'b0;
    game_state = 2'd1;
    repeat (3) @(posedge clk);
    #1 game_state = 2'd2;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    set_reset_cfg();
    chk("midrst_level_up", int'(level_up), 0);
    chk("midrst_level", int'(level_num), 0);
    chk("midrst_time", int'(initial_time), 1500);
    chk("midrst_buttons", int'(button_count), 6);
    repeat (3) @(posedge clk);
    #1 game_state = 2'd0;
    repeat (3) @(posedge clk);

    run_round(2'd2, 1, 1400, 7);
    repeat (5) @(posedge clk);
    chk("queue_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
